// File: rtl/mpu6050_sequencer_if.sv
// Request/response bus between the MPU-6050 sequencer and the i2c_driver.
// The master side issues register transactions; the slave side reports completion.
interface mpu6050_sequencer_if;
  logic       drv_run_req;
  logic       drv_r_en;
  logic [6:0] drv_slave_addr;
  logic [7:0] drv_reg_addr;
  logic [7:0] drv_send_data;
  logic       drv_done;
  logic [7:0] drv_received_data;

  modport master (
    output drv_run_req, drv_r_en, drv_slave_addr, drv_reg_addr, drv_send_data,
    input  drv_done, drv_received_data
  );

  modport slave (
    input  drv_run_req, drv_r_en, drv_slave_addr, drv_reg_addr, drv_send_data,
    output drv_done, drv_received_data
  );
endinterface

// File: rtl/mpu6050_sequencer.sv
// MPU-6050 sequencer: one wake-up write, then periodic burst reads of a register
// window, streamed out byte by byte with frame, overrun and timeout reporting.
module mpu6050_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h68,
  parameter logic [7:0]  WAKE_REG       = 8'h6B,
  parameter logic [7:0]  WAKE_DATA      = 8'h00,
  parameter logic [7:0]  START_ADDR     = 8'h3B,
  parameter int unsigned NUM_REGS       = 6,
  parameter int unsigned PERIOD_CYCLES  = 3000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  mpu6050_sequencer_if.master        bus,
  output logic                       init_done,
  output logic                       sample_valid,
  output logic [3:0]                 sample_idx,
  output logic [7:0]                 sample_byte,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       error
);
  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INIT_REQ, WAIT_TICK, RD_REQ, ERR} state_t;

  state_t        state, state_nx;
  logic [3:0]    idx, idx_nx;
  logic          gap, gap_nx;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic          run_req;
  logic          tick;
  logic          accept;
  logic          timeout;
  logic          last;

  // gap forces the single idle cycle between consecutive bytes of a frame
  assign run_req = (state == INIT_REQ) || ((state == RD_REQ) && !gap);
  assign accept  = run_req && bus.drv_done;
  assign timeout = run_req && !bus.drv_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign tick    = init_done && (pcnt == PW'(PERIOD_CYCLES - 1));
  assign last    = (idx == 4'(NUM_REGS - 1));

  assign bus.drv_run_req    = run_req;
  assign bus.drv_r_en       = (state == RD_REQ);
  assign bus.drv_slave_addr = SLAVE_ADDR;
  assign bus.drv_reg_addr   = (state == INIT_REQ) ? WAKE_REG :
                              (state == RD_REQ)   ? START_ADDR + {4'b0000, idx} : '0;
  assign bus.drv_send_data  = (state == INIT_REQ) ? WAKE_DATA : '0;
  assign error              = (state == ERR);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nx = init_done ? WAIT_TICK : INIT_REQ;
      end
      INIT_REQ: begin
        if (accept)       state_nx = WAIT_TICK;
        else if (timeout) state_nx = ERR;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (tick) begin
          state_nx = RD_REQ;
          idx_nx   = '0;
        end
      end
      RD_REQ: begin
        if (accept) begin
          if (last) begin
            state_nx = WAIT_TICK;
          end else begin
            idx_nx = idx + 4'd1;
            gap_nx = 1'b1;
          end
        end else if (timeout) begin
          state_nx = ERR;
        end
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      gap          <= 1'b0;
      pcnt         <= '0;
      tcnt         <= '0;
      init_done    <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_byte  <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      gap   <= gap_nx;
      if ((state == INIT_REQ) && accept) init_done <= 1'b1;
      // period counter free-runs from the cycle after init_done rises
      if (init_done) pcnt <= tick ? '0 : pcnt + 1'b1;
      tcnt         <= run_req ? tcnt + 1'b1 : '0;
      sample_valid <= (state == RD_REQ) && accept;
      frame_done   <= (state == RD_REQ) && accept && last;
      overrun      <= tick && (state == RD_REQ);
      if ((state == RD_REQ) && accept) begin
        sample_idx  <= idx;
        sample_byte <= bus.drv_received_data;
      end
    end
  end
endmodule

// File: tb/tb_mpu6050_sequencer.sv
// Randomized scoreboard bench for mpu6050_sequencer with a behavioural I2C driver
// model; frame timing and overrun expectations come from the period grid.
module tb_mpu6050_sequencer;
  localparam int P = 300;
  localparam int T = 500;
  localparam int N = 6;

  typedef struct {
    int         idx;
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       init_done, sample_valid, frame_done, overrun, error;
  logic [3:0] sample_idx;
  logic [7:0] sample_byte;

  mpu6050_sequencer_if bus();

  mpu6050_sequencer #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .init_done(init_done), .sample_valid(sample_valid), .sample_idx(sample_idx),
    .sample_byte(sample_byte), .frame_done(frame_done), .overrun(overrun), .error(error)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  int   t_init = 0;
  logic init_prev = 1'b0;
  int   obs_ovr = 0;
  int   exp_ovr = 0;
  int   frames_cnt = 0;
  int   seen[16];
  int   n_req = 0;
  int   lat_lo = 50;
  int   lat_hi = 50;
  logic hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural I2C driver: answers each request after a random latency
  initial begin : driver
    logic        busy = 1'b0;
    logic        need_init = 1'b1;
    logic        first_frame = 1'b1;
    logic        hang_cur = 1'b0;
    logic        expect_rise = 1'b0;
    logic        rise_next = 1'b0;
    logic [16:0] held = '0;
    int          m_idx = 0;
    int          wait_n = 0;
    int          lat_cur = 1;
    int          t_req = 0;
    int          f_start = 0;
    logic [7:0]  rx;
    bus.drv_done = 1'b0;
    bus.drv_received_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.drv_done = 1'b0;
        busy = 1'b0;
        need_init = 1'b1;
        m_idx = 0;
        expect_rise = 1'b0;
      end else begin
        if (expect_rise) begin
          chk("req_gap_len", bus.drv_run_req, 1);
          expect_rise = 1'b0;
        end
        if (bus.drv_done) begin
          bus.drv_done = 1'b0;
          chk("req_low_after_done", bus.drv_run_req, 0);
          expect_rise = rise_next;
        end else if (bus.drv_run_req) begin
          if (!busy) begin
            busy = 1'b1;
            t_req = cyc;
            n_req++;
            wait_n = 0;
            lat_cur = $urandom_range(lat_hi, lat_lo);
            hang_cur = hang && !need_init;
            chk("slave_addr", bus.drv_slave_addr, 7'h68);
            if (need_init) begin
              chk("init_r_en", bus.drv_r_en, 0);
              chk("init_reg", bus.drv_reg_addr, 8'h6B);
              chk("init_data", bus.drv_send_data, 8'h00);
            end else begin
              chk("rd_r_en", bus.drv_r_en, 1);
              chk("rd_reg", bus.drv_reg_addr, 32'h3B + m_idx);
              chk("rd_data", bus.drv_send_data, 0);
              if (m_idx == 0) begin
                f_start = cyc;
                chk("frame_phase", (cyc - t_init) % P, 0);
              end
            end
            held = {bus.drv_r_en, bus.drv_reg_addr, bus.drv_send_data};
          end else begin
            chk("req_hold", {bus.drv_r_en, bus.drv_reg_addr, bus.drv_send_data}, held);
          end
          wait_n++;
          if (!hang_cur && wait_n >= lat_cur) begin
            busy = 1'b0;
            rise_next = 1'b0;
            if (need_init) begin
              need_init = 1'b0;
              bus.drv_received_data = 8'($urandom);
            end else begin
              rx = first_frame ? 8'(8'h10 + m_idx) : 8'($urandom);
              bus.drv_received_data = rx;
              q.push_back('{idx: m_idx, b: rx, last: (m_idx == N - 1)});
              if (m_idx == N - 1) begin
                // every period tick landing inside this frame must raise overrun
                for (int c = f_start; c <= cyc; c++)
                  if ((c + 1 - t_init) % P == 0) exp_ovr++;
                m_idx = 0;
                first_frame = 1'b0;
              end else begin
                m_idx++;
                rise_next = 1'b1;
              end
            end
            bus.drv_done = 1'b1;
          end
        end else if (busy) begin
          busy = 1'b0;
          if (hang_cur) chk("timeout_len", cyc - t_req, T);
          else chk("req_dropped_early", bus.drv_run_req, 1);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a sample
  always @(negedge clk) begin
    exp_t e;
    if (init_done && !init_prev) t_init = cyc;
    init_prev = init_done;
    if (overrun) obs_ovr++;
    if (sample_valid) begin
      if (q.size() == 0) begin
        chk("sample_unexpected", sample_valid, 0);
      end else begin
        e = q.pop_front();
        chk("sample_idx", sample_idx, e.idx);
        chk("sample_byte", sample_byte, e.b);
        chk("frame_done", frame_done, e.last);
        seen[sample_idx]++;
        if (frame_done) begin
          frames_cnt++;
          chk("overrun_count", obs_ovr, exp_ovr);
        end
      end
    end else if (frame_done) begin
      chk("frame_done_alone", frame_done, 0);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_run_req"}, bus.drv_run_req, 0);
    chk({tag, "_r_en"}, bus.drv_r_en, 0);
    chk({tag, "_slave"}, bus.drv_slave_addr, 7'h68);
    chk({tag, "_reg"}, bus.drv_reg_addr, 0);
    chk({tag, "_data"}, bus.drv_send_data, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_idx"}, sample_idx, 0);
    chk({tag, "_byte"}, sample_byte, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_cnt + n;
    int budget = n * 2000;
    while (frames_cnt < target && budget > 0) begin step(); budget--; end
    chk("frames_arrived", frames_cnt, target);
  endtask

  task automatic wait_idx(input int i);
    int target = seen[i] + 1;
    int budget = 2000;
    while (seen[i] < target && budget > 0) begin step(); budget--; end
    chk("idx_arrived", seen[i], target);
  endtask

  task automatic wait_init();
    int budget = 500;
    while (!init_done && budget > 0) begin step(); budget--; end
    chk("init_done_rise", init_done, 1);
  endtask

  initial begin : main
    int snap;
    int budget;
    foreach (seen[i]) seen[i] = 0;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset("por");
    step();
    rst = 1'b0;
    enable = 1'b1;

    // wake-up write, then nominal frames
    wait_init();
    lat_lo = 1;
    lat_hi = 30;
    wait_frames(3);

    // slow driver: frames overrun the period but still complete
    lat_lo = 60;
    lat_hi = 70;
    wait_frames(2);
    chk("overrun_seen", 32'(obs_ovr > 0), 1);

    // enable dropped during byte 2
    lat_lo = 20;
    lat_hi = 20;
    wait_idx(1);
    repeat (3) step();
    enable = 1'b0;
    wait_frames(1);
    snap = n_req;
    repeat (2 * P) step();
    chk("no_req_when_disabled", n_req - snap, 0);
    enable = 1'b1;
    wait_frames(2);

    // reset during byte 3, wake-up write repeated afterwards
    wait_idx(2);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    obs_ovr = 0;
    exp_ovr = 0;
    wait_init();
    wait_frames(1);

    // driver hangs: timeout leads to sticky error
    hang = 1'b1;
    budget = P + T + 200;
    while (!error && budget > 0) begin step(); budget--; end
    chk("error_set", error, 1);
    hang = 1'b0;
    snap = n_req;
    repeat (2 * P) step();
    chk("no_req_after_error", n_req - snap, 0);
    chk("error_sticky", error, 1);
    chk("run_req_in_err", bus.drv_run_req, 0);
    rst = 1'b1;
    enable = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_err");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
